board_mem_arbiter: RTL and testbench

Shares the single-port 256-cell board RAM between the three agents that touch it: mine placement (port 0), neighbour-count pass (port 1) and player reveal/flag logic (port 2). Each requester gets one RAM access per grant. Read data comes back tagged to the issuing port. The block sits between those agents and the board RAM (registered address/data inputs, 1-cycle read latency), replacing direct wiring of the mine placer's memory interface.

---
 rtl/board_mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_board_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: shares the single-port 256-cell board RAM between the
// mine placer (port 0), the neighbour-count pass (port 1) and the player
// reveal/flag logic (port 2).
//
// Pipeline: ARB (sample requests) -> ISSUE (drive RAM, pulse gnt)
//           -> RETURN (RAM data back, pulse rvalid).
//
// Build option: define BOARD_ARB_FIXED_PRIO_EN for strict fixed priority
// (port 0 > port 1 > port 2). When it is left undefined, the arbiter uses
// round-robin starting after the last winner.
module board_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,

    input  logic              r2_req,
    input  logic              r2_we,
    input  logic [ADDR_W-1:0] r2_addr,
    input  logic [DATA_W-1:0] r2_wdata,
    output logic              r2_gnt,
    output logic              r2_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,

    output logic              busy
);

    localparam int NP = 3;

    // Requester fields gathered into indexable form
    logic [NP-1:0]     w_req;
    logic [NP-1:0]     w_we;
    logic [ADDR_W-1:0] w_addr  [NP];
    logic [DATA_W-1:0] w_wdata [NP];

    // Arbitration results
    logic [NP-1:0]     w_elig;
    logic [NP-1:0]     w_win_oh;
    logic [1:0]        w_win_idx;
    logic              w_win_valid;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_we;
    logic [NP-1:0]     w_rvalid;

    // Registered state
    logic [NP-1:0]     r_gnt;        // one-hot: port issued this cycle
    logic [NP-1:0]     r_rv;         // one-hot read tag: port whose data returns this cycle
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
`ifndef BOARD_ARB_FIXED_PRIO_EN
    logic [1:0]        r_last;       // last granted port, round-robin pointer
`endif

    assign w_req      = {r2_req, r1_req, r0_req};
    assign w_we       = {r2_we,  r1_we,  r0_we};
    assign w_addr[0]  = r0_addr;
    assign w_addr[1]  = r1_addr;
    assign w_addr[2]  = r2_addr;
    assign w_wdata[0] = r0_wdata;
    assign w_wdata[1] = r1_wdata;
    assign w_wdata[2] = r2_wdata;

    // A port is masked in its own grant cycle so a held request is not issued twice
    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_elig
            assign w_elig[gi] = w_req[gi] & ~r_gnt[gi];
        end
    endgenerate

`ifdef BOARD_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest-numbered eligible port wins
    always_comb begin
        w_win_oh    = '0;
        w_win_idx   = 2'd0;
        w_win_valid = 1'b0;
        for (int k = NP - 1; k >= 0; k--) begin
            if (w_elig[k]) begin
                w_win_oh    = '0;
                w_win_oh[k] = 1'b1;
                w_win_idx   = 2'(k);
                w_win_valid = 1'b1;
            end
        end
    end
`else
    // Round-robin: search from the port after r_last, wrapping 2 -> 0;
    // scanning farthest-first lets the nearest eligible candidate win
    always_comb begin
        int p;
        w_win_oh    = '0;
        w_win_idx   = 2'd0;
        w_win_valid = 1'b0;
        p           = 0;
        for (int k = NP; k >= 1; k--) begin
            p = int'(r_last) + k;
            if (p >= NP) begin
                p = p - NP;
            end
            if (w_elig[p]) begin
                w_win_oh    = '0;
                w_win_oh[p] = 1'b1;
                w_win_idx   = 2'(p);
                w_win_valid = 1'b1;
            end
        end
    end
`endif

    // Select the winning requester's fields with a one-hot mux
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int k = 0; k < NP; k++) begin
            if (w_win_oh[k]) begin
                w_sel_addr  = w_addr[k];
                w_sel_wdata = w_wdata[k];
                w_sel_we    = w_we[k];
            end
        end
    end

    // Issue stage registers and the 1-deep read tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt       <= '0;
            r_rv        <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
`ifndef BOARD_ARB_FIXED_PRIO_EN
            r_last      <= 2'd2;
`endif
        end else begin
            // A read issued this cycle returns its data next cycle
            r_rv     <= r_mem_we ? '0 : r_gnt;
            r_gnt    <= w_win_oh;
            r_mem_we <= w_win_valid & w_sel_we;
            // Address and data hold their previous values when idle
            if (w_win_valid) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
`ifndef BOARD_ARB_FIXED_PRIO_EN
                r_last      <= w_win_idx;
`endif
            end
        end
    end

    // A read in flight when reset hits must not surface as rvalid
    assign w_rvalid  = r_rv & {NP{~rst}};

    assign r0_gnt    = r_gnt[0];
    assign r1_gnt    = r_gnt[1];
    assign r2_gnt    = r_gnt[2];
    assign r0_rvalid = w_rvalid[0];
    assign r1_rvalid = w_rvalid[1];
    assign r2_rvalid = w_rvalid[2];

    // RAM data arrives one cycle after the address; pass it through while tagged
    assign rdata     = (|w_rvalid) ? mem_q : '0;

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;

    // Any issue this cycle (write or read) or a read tag still pending
    assign busy      = (|r_gnt) | (|r_rv);

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Testbench for board_mem_arbiter: behavioural RAM, per-port request agents
// and a transaction-level reference model (grant order, shadow memory).
module tb_board_mem_arbiter;

    logic       clk;
    logic       rst;
    logic       r0_req, r0_we, r1_req, r1_we, r2_req, r2_we;
    logic [7:0] r0_addr, r1_addr, r2_addr;
    logic [3:0] r0_wdata, r1_wdata, r2_wdata;
    logic       r0_gnt, r1_gnt, r2_gnt;
    logic       r0_rvalid, r1_rvalid, r2_rvalid;
    logic [3:0] rdata;
    logic [7:0] mem_addr;
    logic [3:0] mem_wdata;
    logic       mem_we;
    logic [3:0] mem_q;
    logic       busy;

    board_mem_arbiter #(.ADDR_W(8), .DATA_W(4)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
        .r2_req(r2_req), .r2_we(r2_we), .r2_addr(r2_addr), .r2_wdata(r2_wdata),
        .r2_gnt(r2_gnt), .r2_rvalid(r2_rvalid),
        .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] init_val(input int i);
        return 4'(i * 7 + 3);
    endfunction

    // Board RAM: registered address/data, one-cycle read latency
    logic [3:0] ram [256];
    logic       ram_init;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_q <= ram[mem_addr];
    end

    // Agent state (what each requester presents)
    logic       a_req   [3];
    logic       a_we    [3];
    logic [7:0] a_addr  [3];
    logic [3:0] a_wdata [3];

    // Reference model: expected outputs for the upcoming cycle
    logic [2:0] m_gnt;
    logic       m_we;
    logic [7:0] m_addr;
    logic [3:0] m_wdata;
    int         m_rv_port;
    logic [3:0] m_rv_data;
    logic [3:0] m_issue_rdata;
    int         m_last;
    logic       m_prev_rst;
    logic [3:0] shadow [256];

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs with the model, advance the model
    task automatic do_cycle(input logic rst_v);
        logic [2:0] exp_rv;
        logic       exp_busy;
        int         win;
        int         p;
        int         nrv;
        @(negedge clk);
        rst      = rst_v;
        r0_req   = a_req[0]; r0_we = a_we[0]; r0_addr = a_addr[0]; r0_wdata = a_wdata[0];
        r1_req   = a_req[1]; r1_we = a_we[1]; r1_addr = a_addr[1]; r1_wdata = a_wdata[1];
        r2_req   = a_req[2]; r2_we = a_we[2]; r2_addr = a_addr[2]; r2_wdata = a_wdata[2];
        #1;
        exp_rv   = (m_rv_port >= 0 && !rst_v) ? 3'(3'b001 << m_rv_port) : 3'b000;
        exp_busy = (m_gnt != 3'b000) || (m_rv_port >= 0);
        check_eq("gnt",       32'({r2_gnt, r1_gnt, r0_gnt}),          32'(m_gnt));
        check_eq("rvalid",    32'({r2_rvalid, r1_rvalid, r0_rvalid}), 32'(exp_rv));
        check_eq("mem_we",    32'(mem_we),    32'(m_we));
        check_eq("mem_addr",  32'(mem_addr),  32'(m_addr));
        check_eq("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        check_eq("busy",      32'(busy),      32'(exp_busy));
        if (exp_rv != 3'b000 || m_prev_rst)
            check_eq("rdata", 32'(rdata), (exp_rv != 3'b000) ? 32'(m_rv_data) : 32'd0);
        for (int k = 0; k < 3; k++) begin
            if (m_gnt[k])
                $display("txn t=%0t port=%0d op=%s addr=%02h data=%0h", $time, k,
                         m_we ? "WR" : "RD", m_addr, m_we ? m_wdata : m_issue_rdata);
        end

        if (rst_v) begin
            m_gnt = '0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
            m_rv_port = -1; m_last = 2;
        end else begin
            nrv = -1;
            for (int k = 0; k < 3; k++) if (m_gnt[k] && !m_we) nrv = k;
            if (nrv >= 0) m_rv_data = m_issue_rdata;
            m_rv_port = nrv;
            win = -1;
`ifdef BOARD_ARB_FIXED_PRIO_EN
            for (int k = 0; k < 3; k++)
                if (win < 0 && a_req[k] && !m_gnt[k]) win = k;
`else
            for (int k = 1; k <= 3; k++) begin
                p = (m_last + k) % 3;
                if (win < 0 && a_req[p] && !m_gnt[p]) win = p;
            end
`endif
            m_gnt = '0;
            m_we  = 1'b0;
            if (win >= 0) begin
                m_gnt[win] = 1'b1;
                m_addr     = a_addr[win];
                m_wdata    = a_wdata[win];
                m_we       = a_we[win];
                if (a_we[win]) shadow[m_addr] = m_wdata;
                else           m_issue_rdata  = shadow[m_addr];
                m_last = win;
            end
        end
        m_prev_rst = rst_v;
    endtask

    task automatic new_fields(input int p);
        a_we[p]    = 1'($urandom_range(1));
        a_addr[p]  = 8'($urandom_range(15));
        a_wdata[p] = 4'($urandom_range(15));
    endtask

    // Requests finish on grant; no new requests are raised
    task automatic run_release(input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 3; k++) if (m_gnt[k]) a_req[k] = 1'b0;
            do_cycle(1'b0);
        end
    endtask

    // Random agents: occasional withdrawals, fresh fields after each grant
    task automatic agents_random(input int withdraw_pct, input int new_pct);
        for (int k = 0; k < 3; k++) begin
            if (m_gnt[k]) begin
                a_req[k] = ($urandom_range(99) < new_pct);
                new_fields(k);
            end else if (a_req[k]) begin
                if ($urandom_range(99) < withdraw_pct) a_req[k] = 1'b0;
            end else if ($urandom_range(99) < new_pct) begin
                a_req[k] = 1'b1;
                new_fields(k);
            end
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; ram_init = 1'b1;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
        r2_req = 0; r2_we = 0; r2_addr = 0; r2_wdata = 0;
        for (int k = 0; k < 3; k++) begin
            a_req[k] = 0; a_we[k] = 0; a_addr[k] = 0; a_wdata[k] = 0;
        end
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        m_gnt = '0; m_we = 0; m_addr = '0; m_wdata = '0;
        m_rv_port = -1; m_rv_data = '0; m_issue_rdata = '0; m_last = 2; m_prev_rst = 1'b1;

        // Reset state
        do_cycle(1'b1);
        do_cycle(1'b1);
        ram_init = 1'b0;
        do_cycle(1'b0);

        // Single write: r0 writes 0x1 to 0x2A
        a_req[0] = 1; a_we[0] = 1; a_addr[0] = 8'h2A; a_wdata[0] = 4'h1;
        run_release(4);

        // Read-back by r1
        a_req[1] = 1; a_we[1] = 0; a_addr[1] = 8'h2A;
        run_release(4);

        // Three-way contention with fresh fields after every grant
        for (int k = 0; k < 3; k++) begin a_req[k] = 1; new_fields(k); end
        for (int i = 0; i < 8; i++) begin
            agents_random(0, 100);
            do_cycle(1'b0);
        end
        for (int k = 0; k < 3; k++) a_req[k] = 0;
        run_release(3);

        // r2 streams reads of 0x00..0x03 with req held
        a_req[2] = 1; a_we[2] = 0; a_addr[2] = 8'h00;
        for (int i = 0; i < 12; i++) begin
            if (m_gnt[2]) begin
                if (a_addr[2] == 8'h03) a_req[2] = 0;
                else a_addr[2] = a_addr[2] + 8'd1;
            end
            do_cycle(1'b0);
        end
        run_release(2);

        // Withdrawn request: r0 wins, r1 drops before it is served
        a_req[0] = 1; a_we[0] = 1; a_addr[0] = 8'h10; a_wdata[0] = 4'h5;
        a_req[1] = 1; a_we[1] = 1; a_addr[1] = 8'h77; a_wdata[1] = 4'h9;
        do_cycle(1'b0);
        a_req[1] = 0;
        run_release(4);

        // Reset while an r2 read is in flight
        a_req[2] = 1; a_we[2] = 0; a_addr[2] = 8'h05;
        for (int i = 0; i < 4 && !m_gnt[2]; i++) do_cycle(1'b0);
        a_req[2] = 0;
        do_cycle(1'b0);
        do_cycle(1'b1);
        do_cycle(1'b0);
        do_cycle(1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            agents_random(10, 40);
            do_cycle(1'b0);
        end
        for (int k = 0; k < 3; k++) a_req[k] = 0;
        run_release(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
